// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MIPS MEM-stage data-memory responder with fixed access latency
// Optional build macro: DMEM_ALIGN_CHECK_EN (flag misaligned accesses through rsp_err)
module dmem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2    // 1..15; the wait counter is 4 bits wide
) (
    input  logic        clk,
    input  logic        reset,       // asynchronous, active-low
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_stall
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;

    // Request captured at the accept edge; the MEM stage may change its
    // outputs freely afterwards.
    logic                    cap_we;
    logic [DEPTH_LOG2-1:0]   cap_idx;
    logic [31:0]             cap_wdata;
    logic                    cap_mis;

    logic [31:0]             mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    req_mis;
    logic                    commit;
    logic                    ram_we;

    // Upper address bits alias modulo the RAM size; byte offset only matters
    // when alignment checking is built in.
    logic                    unused_addr_bits;

    assign req_idx          = req_addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_mis = (req_addr[1:0] != 2'b00);
`else
    assign req_mis = 1'b0;
`endif

    // The access takes effect on the edge that leaves WAIT for RESP.
    assign commit = (state == ST_WAIT) && (cnt == 4'd0);
    assign ram_we = commit && cap_we && !cap_mis;

    // Stall the pipeline from the request cycle until the response cycle;
    // RESP itself does not stall so the pipeline advances as RESP ends.
    assign mem_stall = ((state == ST_IDLE) && req_valid) || (state == ST_WAIT);

    // Word RAM: contents survive reset; a store aborted by reset never commits
    // because reset forces the FSM out of WAIT before the next edge.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[cap_idx] <= cap_wdata;
        end
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= 32'd0;
            cap_mis   <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_idx   <= req_idx;
                        cap_wdata <= req_wdata;
                        cap_mis   <= req_mis;
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= cap_mis;
                        // Stores and rejected accesses leave the read data alone.
                        if (!cap_we && !cap_mis) begin
                            rsp_rdata <= mem[cap_idx];
                        end
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int L  = 2;
    localparam int DL = 6;
    localparam int NW = 1 << DL;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_stall;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    bit cmp_en = 1'b0;

    dmem_responder #(.DEPTH_LOG2(DL), .LATENCY(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_stall (mem_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted request at edge a occupies the
    // responder through edge a+L, completes at edge a+L, and the responder
    // is free again for edges after a+L+1.
    int          ecnt = 0;
    int          acc_edge = -1000;
    logic        p_we = 1'b0;
    int          p_idx = 0;
    logic [31:0] p_data = 32'd0;
    logic        p_mis = 1'b0;
    logic [31:0] m_mem [NW];
    logic [31:0] m_rdata = 32'd0;

    always @(posedge clk) begin
        bit was_ready;
        was_ready = reset && (ecnt > acc_edge + L);
        ecnt++;
        if (reset && ecnt == acc_edge + L && !p_mis) begin
            if (p_we) m_mem[p_idx] = p_data;
            else      m_rdata = m_mem[p_idx];
        end
        if (was_ready && req_valid) begin
            acc_edge = ecnt;
            p_we     = req_we;
            p_idx    = int'((req_addr >> 2) % NW);
            p_data   = req_wdata;
            p_mis    = ALIGN && (req_addr % 4 != 0);
        end
    end

    always @(negedge reset) begin
        acc_edge = -1000;
        m_rdata  = 32'd0;
    end

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) pulses++;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            bit   busy;
            bit   v;
            logic e_stall;
            busy    = (ecnt >= acc_edge) && (ecnt <= acc_edge + L);
            v       = (ecnt == acc_edge + L);
            e_stall = busy ? logic'(ecnt < acc_edge + L) : req_valid;
            chk("req_ready", 32'(req_ready), 32'(!busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(v));
            chk("mem_stall", 32'(mem_stall), 32'(e_stall));
            chk("rsp_err",   32'(rsp_err),   32'(v && p_mis));
            chk("rsp_rdata", rsp_rdata, m_rdata);
        end
    end

    task automatic wait_accept(output time t);
        bit got;
        got = 1'b0;
        t = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                @(posedge clk);
                t = $time;
                got = 1'b1;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no req_ready, expected req_ready=1");
        end
    endtask

    task automatic wait_rsp(input time t_acc, output logic [31:0] rdata, output logic err);
        bit got;
        got = 1'b0;
        rdata = 32'hx;
        err = 1'bx;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                rdata = rsp_rdata;
                err   = rsp_err;
                got   = 1'b1;
                chk("rsp_latency", 32'($time - t_acc), 32'(L * 10 + 5));
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL rsp_timeout: got no rsp_valid, expected rsp_valid=1");
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] rdata, output logic err);
        time t;
        @(posedge clk);
        #2;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        wait_accept(t);
        #2;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        wait_rsp(t, rdata, err);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        time         t1, t2, tr;
        int          p0;

        @(posedge clk);
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        chk("rdata_after_reset", rsp_rdata, 32'd0);

        do_req(1'b1, 32'h0000_0010, 32'hCAFE_F00D, rd, er);
        do_req(1'b0, 32'h0000_0010, 32'd0, rd, er);
        chk("load_after_store", rd, 32'hCAFE_F00D);
        chk("load_err", 32'(er), 32'd0);

        do_req(1'b1, 32'h0000_0100, 32'h1234_5678, rd, er);
        do_req(1'b0, 32'h0000_0000, 32'd0, rd, er);
        chk("alias_load", rd, 32'h1234_5678);

        do_req(1'b1, 32'h0000_0020, 32'h0BAD_BEEF, rd, er);

        // Back-to-back loads with req_valid held high.
        @(posedge clk);
        #2;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0010;
        wait_accept(t1);
        #2;
        req_addr = 32'h0000_0100;
        wait_rsp(t1, rd, er);
        chk("b2b_first", rd, 32'hCAFE_F00D);
        wait_accept(t2);
        #2;
        req_valid = 1'b0;
        chk("b2b_spacing", 32'((t2 - t1) / 10), 32'(L + 2));
        wait_rsp(t2, rd, er);
        chk("b2b_second", rd, 32'h1234_5678);

        // Store aborted by reset during WAIT; reset released with a load pending.
        @(posedge clk);
        #2;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'hFFFF_FFFF;
        wait_accept(t1);
        #2;
        req_valid = 1'b0;
        reset     = 1'b0;
        p0        = pulses;
        repeat (2) @(posedge clk);
        #2;
        chk("aborted_store_no_rsp", 32'(pulses - p0), 32'd0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0020;
        reset     = 1'b1;
        tr        = $time;
        wait_accept(t1);
        #2;
        req_valid = 1'b0;
        chk("accept_after_release", 32'(t1 - tr), 32'd8);
        wait_rsp(t1, rd, er);
        chk("aborted_store_old_value", rd, 32'h0BAD_BEEF);

        // Misaligned store to word 8.
        do_req(1'b1, 32'h0000_0022, 32'h55AA_55AA, rd, er);
        chk("misaligned_err", 32'(er), ALIGN ? 32'd1 : 32'd0);
        do_req(1'b0, 32'h0000_0020, 32'd0, rd, er);
        chk("misaligned_word8", rd, ALIGN ? 32'h0BAD_BEEF : 32'h55AA_55AA);

        // Fill every word so random loads have defined expectations.
        for (int w = 0; w < NW; w++) begin
            do_req(1'b1, 32'(w * 4), $urandom, rd, er);
        end

        // Random traffic with aliasing addresses and random gaps.
        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_req(1'($urandom), $urandom, $urandom, rd, er);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
